// File: rtl/turfio_mode1_arbiter.sv
// turfio_mode1_arbiter: packet-granular round-robin arbiter feeding the TURFIO mode1 command stream.
module turfio_mode1_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              sysclk_i,
  input  logic              rst_i,
  input  logic [8*NREQ-1:0] s_tdata,
  input  logic [2*NREQ-1:0] s_tuser,
  input  logic [3*NREQ-1:0] s_tdest,
  input  logic [NREQ-1:0]   s_tlast,
  input  logic [NREQ-1:0]   s_tvalid,
  output logic [NREQ-1:0]   s_tready,
  output logic [7:0]        m_tdata,
  output logic [1:0]        m_tuser,
  output logic [2:0]        m_tdest,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [NREQ-1:0]   grant_o,
  output logic              timeout_o,
  output logic [15:0]       timeout_count_o
);
  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, LOCK} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, rr_idx, cand;
  logic [NREQ-1:0] gnt_oh;
  logic sel_valid;
  logic last_q, last_d, m_tvalid_q, m_tvalid_d, timeout_q, timeout_d;
  logic [7:0] data_q, data_d;
  logic [1:0] user_q, user_d;
  logic [2:0] dest_q, dest_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] tcnt_q, tcnt_d;
  assign gnt_oh    = NREQ'(1) << gnt_q;
  assign sel_valid = |(s_tvalid & gnt_oh);
  assign grant_o   = (state_q == IDLE) ? '0 : gnt_oh;
  assign s_tready  = (state_q == LOAD) ? (s_tvalid & gnt_oh) : '0;
  assign m_tdata   = data_q;
  assign m_tuser   = user_q;
  assign m_tdest   = dest_q;
  assign m_tvalid  = m_tvalid_q;
  assign timeout_o = timeout_q;
  assign timeout_count_o = tcnt_q;
  // Scan downward so the nearest valid index after ptr wins.
  always_comb begin
    rr_idx = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(ptr_q) + k) % NREQ);
      if (s_tvalid[cand]) rr_idx = cand;
    end
  end
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    m_tvalid_d = m_tvalid_q;
    data_d     = data_q;
    user_d     = user_q;
    dest_d     = dest_q;
    timer_d    = timer_q;
    tcnt_d     = tcnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: if (|s_tvalid) begin
        gnt_d   = rr_idx;
        state_d = LOAD;
      end
      LOAD: if (sel_valid) begin
        data_d     = s_tdata[8*gnt_q +: 8];
        user_d     = s_tuser[2*gnt_q +: 2];
        dest_d     = s_tdest[3*gnt_q +: 3];
        last_d     = s_tlast[gnt_q];
        m_tvalid_d = 1'b1;
        state_d    = SEND;
      end else begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      SEND: if (m_tready) begin
        m_tvalid_d = 1'b0;
        timer_d    = '0;
        ptr_d      = last_q ? gnt_q : ptr_q;
        state_d    = last_q ? IDLE : LOCK;
      end
      LOCK: if (sel_valid) state_d = LOAD;
      else if (timer_q == TW'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
        tcnt_d    = tcnt_q + 16'(tcnt_q != 16'hFFFF);
        timer_d   = '0;
        ptr_d     = gnt_q;
        state_d   = IDLE;
      end else timer_d = timer_q + TW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= GW'(NREQ - 1);
      last_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      data_q     <= '0;
      user_q     <= '0;
      dest_q     <= '0;
      timer_q    <= '0;
      tcnt_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      m_tvalid_q <= m_tvalid_d;
      data_q     <= data_d;
      user_q     <= user_d;
      dest_q     <= dest_d;
      timer_q    <= timer_d;
      tcnt_q     <= tcnt_d;
      timeout_q  <= timeout_d;
    end
  end
endmodule
